// File: rtl/slm_seq_pkg.sv
// slm_seq_pkg: shared types and default constants for the SLM line sequencer.
//   seq_state_t       - sequencer FSM states (also exported on dbg_state)
//   DEF_*             - default parameter values for slm_line_sequencer
//   WCNT_W            - width of the per-line word counter
package slm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINE = 3'd1,
        READ_LINE = 3'd2,
        DRAIN     = 3'd3,
        LATCH     = 3'd4,
        NEXT_ROW  = 3'd5
    } seq_state_t;

    localparam int DEF_WORDS_PER_LINE  = 64;
    localparam int DEF_LINES_PER_FRAME = 1024;
    localparam int DEF_WORD_W          = 32;
    localparam int DEF_ROW_W           = 10;

    // Word counter width; covers WORDS_PER_LINE up to 127.
    localparam int WCNT_W = 7;

endpackage

// File: rtl/slm_word_pipe.sv
// slm_word_pipe: one register stage between the input word buffer and the
// SLM shift-register interface.
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_en      : buffer pop strobe issued by the sequencer
//   rd_data    : buffer head word, sampled on the same edge as the pop
//   data       : registered word towards the SLM
//   valid      : rd_en delayed by exactly one cycle, qualifies data
//
// Handshake: the buffer presents its head word on rd_data; a word is
// transferred on every rising edge where rd_en is high. There is no
// backpressure from the SLM side, so valid is a pure one-cycle delay of rd_en.
module slm_word_pipe #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] data,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= rd_en;
            // Hold the last word between pops so slm_data only moves with valid.
            if (rd_en) begin
                data <= rd_data;
            end
        end
    end

endmodule

// File: rtl/slm_line_sequencer.sv
// slm_line_sequencer: moves display data from the input word buffer to the SLM
// row-write interface one line at a time. A frame starts on next_frame_rdy;
// each line starts on line_of_data_available, bursts WORDS_PER_LINE words,
// then pulses the row latch with the row address.
//
// Ports:
//   fpga_clk, reset_n       : clock, asynchronous active-low reset
//   next_frame_rdy          : level, frame may begin (only looked at in IDLE)
//   line_of_data_available  : level, at least one line buffered
//   num_words_in_buffer     : buffer occupancy (used by the underflow guard)
//   buf_rd_data / buf_rd_en : buffer head word / pop strobe
//   slm_data / slm_data_valid : word to SLM and its qualifier (1 cycle after pop)
//   slm_row_addr            : row being written, stable through its strobe
//   slm_row_strobe          : one-cycle row latch pulse after the last word
//   slm_frame_sync          : one-cycle pulse on entering WAIT_LINE for row 0
//   busy                    : high in every state except IDLE
//   underflow_err           : sticky, set by a zero-occupancy cycle in READ_LINE
//   dbg_state               : current FSM state (seq_state_t encoding)
//
// Build option: define SLM_UNDERFLOW_GUARD_EN to gate pops on non-zero
// occupancy and report underflow; otherwise pops are unconditional and
// underflow_err is tied low.
//
// Handshake: buf_rd_en is a pop request with no ready; the buffer must hold at
// least one word whenever buf_rd_en is high (guaranteed by the
// line_of_data_available contract, or by the guard when enabled).
import slm_seq_pkg::*;

module slm_line_sequencer #(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int WORD_W          = DEF_WORD_W,
    parameter int ROW_W           = DEF_ROW_W
) (
    input  logic              fpga_clk,
    input  logic              reset_n,
    input  logic              next_frame_rdy,
    input  logic              line_of_data_available,
    input  logic [6:0]        num_words_in_buffer,
    input  logic [WORD_W-1:0] buf_rd_data,
    output logic              buf_rd_en,
    output logic [WORD_W-1:0] slm_data,
    output logic              slm_data_valid,
    output logic [ROW_W-1:0]  slm_row_addr,
    output logic              slm_row_strobe,
    output logic              slm_frame_sync,
    output logic              busy,
    output logic              underflow_err,
    output logic [2:0]        dbg_state
);

    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(LINES_PER_FRAME - 1);

    seq_state_t        state_q, state_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              frame_sync_q, frame_sync_d;
    logic              pop_ok;
    logic              pop;

`ifdef SLM_UNDERFLOW_GUARD_EN
    assign pop_ok = (num_words_in_buffer != 7'd0);
`else
    assign pop_ok = 1'b1;
`endif

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            row_q        <= '0;
            frame_sync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            row_q        <= row_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        row_d        = row_q;
        frame_sync_d = 1'b0;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (next_frame_rdy) begin
                    state_d      = WAIT_LINE;
                    row_d        = '0;
                    // Registered so the pulse lines up with the first WAIT_LINE cycle.
                    frame_sync_d = 1'b1;
                end
            end
            WAIT_LINE: begin
                if (line_of_data_available) begin
                    state_d    = READ_LINE;
                    word_cnt_d = '0;
                end
            end
            READ_LINE: begin
                // Committed once entered: line_of_data_available is not rechecked.
                pop = pop_ok;
                if (pop) begin
                    word_cnt_d = word_cnt_q + WCNT_W'(1);
                    if (word_cnt_q == WORD_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Last word is on slm_data during this cycle.
                state_d = LATCH;
            end
            LATCH: begin
                state_d = NEXT_ROW;
            end
            NEXT_ROW: begin
                // Row advances only after its strobe, keeping slm_row_addr stable.
                if (row_q == ROW_LAST) begin
                    state_d = IDLE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    state_d = WAIT_LINE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    slm_word_pipe #(
        .WORD_W (WORD_W)
    ) u_word_pipe (
        .clk     (fpga_clk),
        .rst_n   (reset_n),
        .rd_en   (pop),
        .rd_data (buf_rd_data),
        .data    (slm_data),
        .valid   (slm_data_valid)
    );

`ifdef SLM_UNDERFLOW_GUARD_EN
    logic underflow_q;

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_q <= 1'b0;
        end else if (state_q == READ_LINE && num_words_in_buffer == 7'd0) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow_err = underflow_q;
`else
    // Occupancy is only needed by the guard.
    logic unused_num_words;
    assign unused_num_words = ^num_words_in_buffer;
    assign underflow_err    = 1'b0;
`endif

    assign buf_rd_en      = pop;
    assign slm_row_addr   = row_q;
    assign slm_row_strobe = (state_q == LATCH);
    assign slm_frame_sync = frame_sync_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;

endmodule
